// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester sequential Booth multiplier.
//   DEFAULT_WIDTH : default operand width in bits (product is 2*WIDTH)
//   CNT_WIDTH     : step counter width for the default operand width
//   state_t       : controller states IDLE / RUN / DONE
//   cnt_width()   : step counter width for any operand width
package mult_arb_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_WIDTH     = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter has to hold the value WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Handshake bundle between two requesters, one consumer and mult_arbiter.
//   req0_* / req1_* : valid/ready handshake plus signed operands m and q
//   resp_*          : valid/ready handshake plus owner id, product, overflow
// master : the side that issues requests and consumes responses
// slave  : the multiplier
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_m;
    logic [WIDTH-1:0]     req0_q;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_m;
    logic [WIDTH-1:0]     req1_q;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_id;
    logic [2*WIDTH-1:0]   resp_product;
    logic                 resp_overflow;

    modport master (
        output req0_valid, req0_m, req0_q,
        output req1_valid, req1_m, req1_q,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_product, resp_overflow
    );

    modport slave (
        input  req0_valid, req0_m, req0_q,
        input  req1_valid, req1_m, req1_q,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_product, resp_overflow
    );

endinterface

// File: rtl/mult_arbiter_booth_seq_core.sv
// Sequential radix-2 Booth multiplier datapath, one step per clock.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture m and q, clear accumulator upper part and counter
//   step     : perform one Booth step (add/sub m, arithmetic shift right)
//   m, q     : signed multiplicand / multiplier
//   product  : signed 2*WIDTH-bit product, valid once done is high
//   done     : WIDTH steps have been performed since the last load
module booth_seq_core
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = cnt_width(WIDTH);

    // Accumulator = {upper_reg, lower_reg, q_prev_reg}. The upper part carries
    // one extra bit so that subtracting m = -2^(WIDTH-1) cannot wrap.
    logic [WIDTH:0]   upper_reg;
    logic [WIDTH-1:0] lower_reg;
    logic             q_prev_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count_reg;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   upper_sum;

    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        upper_sum = upper_reg;
        case ({lower_reg[0], q_prev_reg})
            2'b01:   upper_sum = upper_reg + m_ext;
            2'b10:   upper_sum = upper_reg - m_ext;
            default: upper_sum = upper_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upper_reg  <= '0;
            lower_reg  <= '0;
            q_prev_reg <= 1'b0;
            m_reg      <= '0;
            count_reg  <= '0;
        end else if (load) begin
            upper_reg  <= '0;
            lower_reg  <= q;
            q_prev_reg <= 1'b0;
            m_reg      <= m;
            count_reg  <= '0;
        end else if (step) begin
            // Arithmetic shift of the whole accumulator by one position.
            upper_reg  <= {upper_sum[WIDTH], upper_sum[WIDTH:1]};
            lower_reg  <= {upper_sum[0], lower_reg[WIDTH-1:1]};
            q_prev_reg <= lower_reg[0];
            count_reg  <= count_reg + 1'b1;
        end
    end

    // The extra guard bit of the upper part is only a sign copy at the end.
    assign product = {upper_reg[WIDTH-1:0], lower_reg};
    assign done    = (count_reg == CW'(WIDTH));

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end sharing one sequential Booth multiplier.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mult_arbiter_if.slave -- req0/req1 operand handshakes and the
//              result handshake (resp_id, resp_product, resp_overflow)
// A request is accepted only in IDLE; the result appears WIDTH+1 clocks after
// the accepting edge and is held until the consumer takes it.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    mult_arbiter_if.slave   bus
);

    state_t               state_reg;
    logic                 last_grant_reg;
    logic                 owner_reg;
    logic                 resp_valid_reg;
    logic                 resp_id_reg;
    logic [2*WIDTH-1:0]   resp_product_reg;
    logic                 resp_overflow_reg;

    logic                 grant_any;
    logic                 grant_id;
    logic [WIDTH-1:0]     m_sel;
    logic [WIDTH-1:0]     q_sel;
    logic                 core_step;
    logic                 core_done;
    logic [2*WIDTH-1:0]   core_product;
    logic [WIDTH:0]       product_top;
    logic                 core_overflow;

    // Grant logic is the only valid->ready path. rst gates it so that both
    // ready outputs read 0 while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state_reg == IDLE && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant_reg;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_any && !grant_id;
    assign bus.req1_ready = grant_any &&  grant_id;

    // A grant only happens for a valid requester, so grant == handshake.
    assign m_sel     = grant_id ? bus.req1_m : bus.req0_m;
    assign q_sel     = grant_id ? bus.req1_q : bus.req0_q;
    assign core_step = (state_reg == RUN) && !core_done;

    booth_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (grant_any),
        .step    (core_step),
        .m       (m_sel),
        .q       (q_sel),
        .product (core_product),
        .done    (core_done)
    );

    // Fits in WIDTH signed bits iff the top WIDTH+1 bits are all copies of one bit.
    assign product_top   = core_product[2*WIDTH-1:WIDTH-1];
    assign core_overflow = !((&product_top) || !(|product_top));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            last_grant_reg    <= 1'b1;   // requester 0 wins the first tie
            owner_reg         <= 1'b0;
            resp_valid_reg    <= 1'b0;
            resp_id_reg       <= 1'b0;
            resp_product_reg  <= '0;
            resp_overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        owner_reg      <= grant_id;
                        last_grant_reg <= grant_id;
                        state_reg      <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        resp_valid_reg    <= 1'b1;
                        resp_id_reg       <= owner_reg;
                        resp_product_reg  <= core_product;
                        resp_overflow_reg <= core_overflow;
                        state_reg         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid    = resp_valid_reg;
    assign bus.resp_id       = resp_id_reg;
    assign bus.resp_product  = resp_product_reg;
    assign bus.resp_overflow = resp_overflow_reg;

endmodule
